// File: rtl/dispenser_pkg.sv
// Shared types and defaults for the coin payout engine.
// Holds the FSM state encoding and the sizing helper for the shared cycle timer.
package dispenser_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EJECT,
      ST_RELEASE,
      ST_GAP,
      ST_FAULT
   } state_e;

   localparam int DEF_WIDTH     = 8;
   localparam int DEF_PULSE_GAP = 4;
   localparam int DEF_TIMEOUT   = 1000;

   // One timer serves both the ack timeout and the inter-coin gap, so it must
   // hold the larger of the two load values.
   function automatic int timer_width(input int timeout, input int pulse_gap);
      int max_val;
      max_val = (timeout > pulse_gap) ? timeout : pulse_gap;
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter with a zero flag; saturates at zero.
// Shared by the dispenser for ack-timeout and inter-coin gap counting.
module cycle_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         en,
   output logic         zero
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_value;
      end else if (en && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/coin_dispenser.sv
// Payout engine: validates a withdrawal against the balance, then ejects coins
// one at a time over a level handshake, strobing dec once per coin released.
module coin_dispenser
   import dispenser_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int PULSE_GAP = DEF_PULSE_GAP,
   parameter int TIMEOUT   = DEF_TIMEOUT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   input  logic [WIDTH-1:0] req_amount,
   output logic             req_ready,
   input  logic [WIDTH-1:0] balance,
   input  logic             abort,
   output logic             eject,
   input  logic             eject_ack,
   output logic             dec,
   output logic [WIDTH-1:0] remaining,
   output logic             busy,
   output logic             done,
   output logic             err_insufficient,
   output logic             fault
);

   localparam int TW = timer_width(TIMEOUT, PULSE_GAP);
   localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT);
   localparam logic [TW-1:0] GAP_LOAD     = TW'(PULSE_GAP);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] remaining_q, remaining_d;
   logic             eject_q, eject_d;
   logic             dec_q, dec_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             fault_q, fault_d;
   logic             abort_pend_q, abort_pend_d;
   logic             timer_load;
   logic [TW-1:0]    timer_load_value;
   logic             timer_en;
   logic             timer_zero;

   assign req_ready = (state_q == ST_IDLE) && !eject_ack;
   assign busy      = (state_q != ST_IDLE);

   always_comb begin
      state_d      = state_q;
      remaining_d  = remaining_q;
      dec_d        = 1'b0;
      done_d       = 1'b0;
      err_d        = 1'b0;
      abort_pend_d = abort_pend_q;

      case (state_q)
         ST_IDLE: begin
            abort_pend_d = 1'b0;
            if (req_valid && req_ready) begin
               if (req_amount > balance) begin
                  err_d = 1'b1;
               end else if (req_amount == '0) begin
                  done_d = 1'b1;
               end else begin
                  remaining_d = req_amount;
                  state_d     = ST_EJECT;
               end
            end
         end

         ST_EJECT: begin
            // An ack that arrives with abort still pays for the coin it reports.
            if (eject_ack) begin
               dec_d       = 1'b1;
               remaining_d = remaining_q - 1'b1;
               state_d     = abort ? ST_IDLE : ST_RELEASE;
            end else if (abort) begin
               state_d = ST_IDLE;
            end else if (timer_zero) begin
               state_d = ST_FAULT;
            end
         end

         ST_RELEASE: begin
            if (abort) begin
               abort_pend_d = 1'b1;
            end
            if (!eject_ack) begin
               if (abort || abort_pend_q) begin
                  abort_pend_d = 1'b0;
                  state_d      = ST_IDLE;
               end else if (remaining_q == '0) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else if (PULSE_GAP == 0) begin
                  state_d = ST_EJECT;
               end else begin
                  state_d = ST_GAP;
               end
            end
         end

         ST_GAP: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (timer_zero) begin
               state_d = ST_EJECT;
            end
         end

         ST_FAULT: begin
            if (abort) begin
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      eject_d = (state_d == ST_EJECT);
      fault_d = (state_d == ST_FAULT);
   end

   // Reload on every state entry; the loaded value depends on the state entered.
   assign timer_load       = (state_d != state_q);
   assign timer_load_value = (state_d == ST_GAP) ? GAP_LOAD : TIMEOUT_LOAD;
   assign timer_en         = (state_q == ST_EJECT) || (state_q == ST_GAP);

   cycle_timer #(
      .W(TW)
   ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .load      (timer_load),
      .load_value(timer_load_value),
      .en        (timer_en),
      .zero      (timer_zero)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         remaining_q  <= '0;
         eject_q      <= 1'b0;
         dec_q        <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         fault_q      <= 1'b0;
         abort_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         remaining_q  <= remaining_d;
         eject_q      <= eject_d;
         dec_q        <= dec_d;
         done_q       <= done_d;
         err_q        <= err_d;
         fault_q      <= fault_d;
         abort_pend_q <= abort_pend_d;
      end
   end

   assign eject            = eject_q;
   assign dec              = dec_q;
   assign done             = done_q;
   assign err_insufficient = err_q;
   assign fault            = fault_q;
   assign remaining        = remaining_q;

endmodule

// File: tb/tb_coin_dispenser.sv
// Directed bench for coin_dispenser: payout, rejection, timeout, abort races,
// async reset and back-to-back requests, with hand-computed expectations.
module tb_coin_dispenser;

   localparam int W  = 8;
   localparam int PG = 2;
   localparam int TO = 10;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         req_valid = 1'b0;
   logic [W-1:0] req_amount = '0;
   logic         req_ready;
   logic [W-1:0] balance = '0;
   logic         abort = 1'b0;
   logic         eject;
   logic         eject_ack = 1'b0;
   logic         dec;
   logic [W-1:0] remaining;
   logic         busy;
   logic         done;
   logic         err_insufficient;
   logic         fault;

   int tests_run = 0;
   int tests_failed = 0;

   int dec_cnt = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int rise_cnt = 0;
   int low_run = 0;
   int last_gap = 0;
   logic eject_prev = 1'b0;

   coin_dispenser #(
      .WIDTH    (W),
      .PULSE_GAP(PG),
      .TIMEOUT  (TO)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .req_valid       (req_valid),
      .req_amount      (req_amount),
      .req_ready       (req_ready),
      .balance         (balance),
      .abort           (abort),
      .eject           (eject),
      .eject_ack       (eject_ack),
      .dec             (dec),
      .remaining       (remaining),
      .busy            (busy),
      .done            (done),
      .err_insufficient(err_insufficient),
      .fault           (fault)
   );

   always #5 clk = ~clk;

   // Event counters and eject idle-run tracker, sampled on the falling edge.
   always @(negedge clk) begin
      if (dec)              dec_cnt  <= dec_cnt + 1;
      if (done)             done_cnt <= done_cnt + 1;
      if (err_insufficient) err_cnt  <= err_cnt + 1;
      if (eject && !eject_prev) begin
         rise_cnt <= rise_cnt + 1;
         last_gap <= low_run;
      end
      low_run    <= eject ? 0 : low_run + 1;
      eject_prev <= eject;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic wait_eject(input logic level, input int budget, input string tag);
      int n;
      n = 0;
      while (eject !== level && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (eject !== level) check_val(tag, {31'b0, eject}, {31'b0, level});
   endtask

   task automatic serve_coin(input int ack_dly, input int rel_dly);
      wait_eject(1'b1, 40, "coin_eject_high_timeout");
      repeat (ack_dly) @(negedge clk);
      eject_ack = 1'b1;
      wait_eject(1'b0, 40, "coin_eject_low_timeout");
      repeat (rel_dly) @(negedge clk);
      eject_ack = 1'b0;
   endtask

   task automatic send_req(input logic [W-1:0] amt, input logic [W-1:0] bal);
      req_amount = amt;
      balance    = bal;
      req_valid  = 1'b1;
      @(negedge clk);
      req_valid  = 1'b0;
   endtask

   initial begin
      int d0, n0, e0, r0, k;

      // Reset state
      repeat (2) @(negedge clk);
      check_val("rst_eject", eject, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_remaining", remaining, 0);
      check_val("rst_fault", fault, 0);
      check_val("rst_done", done, 0);
      check_val("rst_req_ready", req_ready, 1);
      reset = 1'b0;
      @(negedge clk);

      // Basic payout: 3 coins, ack 2 cycles after eject, release 1 cycle later
      d0 = dec_cnt; n0 = done_cnt; e0 = err_cnt; r0 = rise_cnt;
      send_req(8'd3, 8'd10);
      check_val("basic_eject_after_accept", eject, 1);
      check_val("basic_remaining_start", remaining, 3);
      check_val("basic_busy", busy, 1);
      serve_coin(2, 1);
      check_val("basic_remaining_after1", remaining, 2);
      serve_coin(2, 1);
      serve_coin(2, 1);
      @(negedge clk);
      check_val("basic_done_strobe", done, 1);
      check_val("basic_remaining_end", remaining, 0);
      check_val("basic_idle_gap", last_gap, PG + 3);
      @(negedge clk);
      check_val("basic_done_one_cycle", done, 0);
      check_val("basic_dec_count", dec_cnt - d0, 3);
      check_val("basic_done_count", done_cnt - n0, 1);
      check_val("basic_eject_count", rise_cnt - r0, 3);
      check_val("basic_err_count", err_cnt - e0, 0);
      $display("[TB] txn basic_payout amount=3 balance=10 decs=%0d", dec_cnt - d0);

      // Timeout: no ack ever arrives
      send_req(8'd1, 8'd5);
      wait_eject(1'b1, 5, "to_eject_rise_timeout");
      k = 0;
      while (!fault && k < 40) begin
         @(negedge clk);
         k++;
      end
      check_val("to_cycles_to_fault", k, TO + 1);
      check_val("to_eject_low", eject, 0);
      check_val("to_busy", busy, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_val("to_abort_fault_clear", fault, 0);
      check_val("to_abort_idle", busy, 0);
      check_val("to_abort_remaining", remaining, 1);
      $display("[TB] txn timeout amount=1 fault_after=%0d", k);

      // Rejection, then zero-amount request
      n0 = done_cnt; r0 = rise_cnt;
      send_req(8'd5, 8'd2);
      check_val("rej_err_strobe", err_insufficient, 1);
      check_val("rej_no_eject", eject, 0);
      check_val("rej_idle", busy, 0);
      check_val("rej_remaining_held", remaining, 1);
      @(negedge clk);
      check_val("rej_err_one_cycle", err_insufficient, 0);
      send_req(8'd0, 8'd2);
      check_val("zero_done_strobe", done, 1);
      check_val("zero_idle", busy, 0);
      @(negedge clk);
      check_val("zero_no_eject", rise_cnt - r0, 0);
      $display("[TB] txn reject amount=5 balance=2 then amount=0");

      // Balance with MSB set must compare unsigned; then abort in EJECT
      send_req(8'd5, 8'h90);
      check_val("uns_no_err", err_insufficient, 0);
      check_val("uns_eject", eject, 1);
      check_val("uns_remaining", remaining, 5);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_val("uns_abort_idle", busy, 0);
      check_val("uns_abort_remaining", remaining, 5);
      $display("[TB] txn unsigned amount=5 balance=144 aborted");

      // Abort together with ack in EJECT
      n0 = done_cnt;
      send_req(8'd3, 8'd10);
      eject_ack = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_val("race_dec", dec, 1);
      check_val("race_remaining", remaining, 2);
      check_val("race_idle", busy, 0);
      check_val("race_eject_low", eject, 0);
      check_val("race_ready_blocked", req_ready, 0);
      eject_ack = 1'b0;
      @(negedge clk);
      check_val("race_ready_after_release", req_ready, 1);
      check_val("race_no_done", done_cnt - n0, 0);
      $display("[TB] txn abort_with_ack amount=3");

      // Abort during RELEASE while ack still high
      n0 = done_cnt; r0 = rise_cnt;
      send_req(8'd3, 8'd10);
      eject_ack = 1'b1;
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_val("rel_abort_still_busy", busy, 1);
      check_val("rel_abort_eject_low", eject, 0);
      @(negedge clk);
      check_val("rel_abort_held", busy, 1);
      eject_ack = 1'b0;
      @(negedge clk);
      check_val("rel_abort_idle", busy, 0);
      check_val("rel_abort_remaining", remaining, 2);
      repeat (6) @(negedge clk);
      check_val("rel_abort_no_done", done_cnt - n0, 0);
      check_val("rel_abort_one_eject", rise_cnt - r0, 1);
      $display("[TB] txn abort_in_release amount=3");

      // Back-to-back: 2 coins (equal to balance) then 1 coin held on req_valid
      d0 = dec_cnt; n0 = done_cnt; r0 = rise_cnt;
      req_amount = 8'd2;
      balance    = 8'd2;
      req_valid  = 1'b1;
      @(negedge clk);
      req_amount = 8'd1;
      check_val("b2b_equal_accepted", eject, 1);
      serve_coin(0, 0);
      serve_coin(0, 0);
      check_val("b2b_min_gap", last_gap, PG + 2);
      wait_eject(1'b1, 20, "b2b_second_accept_timeout");
      req_valid = 1'b0;
      check_val("b2b_second_remaining", remaining, 1);
      serve_coin(0, 0);
      repeat (3) @(negedge clk);
      check_val("b2b_dec_count", dec_cnt - d0, 3);
      check_val("b2b_done_count", done_cnt - n0, 2);
      check_val("b2b_eject_count", rise_cnt - r0, 3);
      $display("[TB] txn back_to_back amounts=2,1 decs=%0d", dec_cnt - d0);

      // Asynchronous reset mid-payout
      send_req(8'd3, 8'd10);
      eject_ack = 1'b1;
      #2 reset = 1'b1;
      #1;
      check_val("arst_eject", eject, 0);
      check_val("arst_busy", busy, 0);
      check_val("arst_remaining", remaining, 0);
      check_val("arst_ready_blocked", req_ready, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_val("arst_ready_still_blocked", req_ready, 0);
      eject_ack = 1'b0;
      @(negedge clk);
      check_val("arst_ready_after_release", req_ready, 1);
      $display("[TB] txn async_reset_mid_payout");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/coin_dispenser.md
# coin_dispenser

Payout engine for the piggy-bank datapath. It accepts a withdrawal request for N coins and checks it against the current balance from the coin counter. It then drives the coin ejector one coin at a time through a level handshake, and emits one decrement strobe per coin actually ejected so the counter's balance tracks the coins paid out. It is the outbound counterpart of the coin-counting path: that path counts coin pulses in, this block produces coin pulses out.

## Interface
Parameters:
- WIDTH, 8: width of amounts and balance.
- PULSE_GAP, 4: minimum idle cycles between consecutive ejects (0 allowed).
- TIMEOUT, 1000: cycles allowed for the ejector to acknowledge before faulting (≥1).

Ports:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-high reset.
- req_valid, in, 1: withdrawal request present.
- req_amount, in, WIDTH: number of coins requested.
- req_ready, out, 1: block can accept a request.
- balance, in, WIDTH: current coin count from the counter.
- abort, in, 1: cancel the payout in progress.
- eject, out, 1: command to the ejector to release one coin (level).
- eject_ack, in, 1: ejector reports a coin released (level, held until eject drops).
- dec, out, 1: one-cycle strobe telling the counter to decrement by 1.
- remaining, out, WIDTH: coins still to pay in the current request.
- busy, out, 1: payout in progress (any state other than IDLE).
- done, out, 1: one-cycle strobe when a request completes normally.
- err_insufficient, out, 1: one-cycle strobe when a request is rejected.
- fault, out, 1: ejector timeout; held until abort or reset.

## Operation
- States: IDLE, EJECT, RELEASE, GAP, FAULT.
- Reset values: state IDLE; remaining 0; eject, dec, done, err_insufficient, fault, busy all 0.
- req_ready = (state==IDLE) && !eject_ack. A request is accepted on an edge where req_valid && req_ready.
- On accept:
  - If req_amount > balance: err_insufficient pulses for 1 cycle, state stays IDLE, remaining is unchanged, no eject.
  - Else if req_amount == 0: done pulses for 1 cycle, state stays IDLE.
  - Else: remaining <= req_amount, state goes to EJECT.
- The balance comparison is unsigned and done once, at accept. Later changes to balance are ignored until the next request.
- EJECT: eject=1; the timer counts cycles in this state.
  - If eject_ack=1: dec pulses, remaining decrements, state goes to RELEASE.
  - Else, when the timer reaches TIMEOUT: state goes to FAULT.
- RELEASE: eject=0; wait for eject_ack=0. Then:
  - If remaining==0: done pulses and state goes to IDLE.
  - Else if PULSE_GAP==0: state goes to EJECT.
  - Else: state goes to GAP.
- GAP: count PULSE_GAP cycles, then go to EJECT.
- FAULT: fault=1, eject=0; exit only via abort or reset.
- Abort:
  - abort=1 in EJECT, GAP or FAULT: next state is IDLE. No done strobe. fault clears. remaining holds its value for diagnosis.
  - In RELEASE, abort is latched and applied when eject_ack drops, so the ejector is never left mid-handshake.
- Simultaneous abort and eject_ack in EJECT: the coin counts. dec pulses, remaining decrements, then state goes to IDLE.
- remaining never wraps. It decrements only in EJECT on ack, and is ≥1 whenever the block is in EJECT.
- Reset mid-payout: all outputs return to reset values at once. eject drops asynchronously.

## Timing
- Accept edge to eject high: 1 cycle.
- dec is registered: asserted the cycle after eject_ack is sampled high in EJECT, and high for exactly 1 cycle.
- Minimum cycles per coin with immediate ack and release: 3 + PULSE_GAP (EJECT, RELEASE, GAP, EJECT…).
- done asserts the cycle after eject_ack is sampled low for the last coin.
- Timeout: fault rises TIMEOUT+1 cycles after eject rises when no ack arrives.
- All outputs are registered except req_ready and busy, which decode state.

## Structure
- The shared package dispenser_pkg holds:
  - the state encoding (IDLE, EJECT, RELEASE, GAP, FAULT);
  - default WIDTH, PULSE_GAP and TIMEOUT constants;
  - the timer width function clog2(max(TIMEOUT, PULSE_GAP)+1).
- One sub-module, cycle_timer: a loadable down-counter with a zero flag, shared between the timeout and gap counting. It reloads on every state entry.
- The FSM, remaining register and strobes live in coin_dispenser.

## Test plan
- Basic payout: balance=10, req_amount=3, ejector acks 2 cycles after eject and releases 1 cycle later → exactly 3 eject pulses and 3 dec strobes, remaining 3→0, one done, ≥PULSE_GAP idle cycles between ejects.
- Rejection: balance=2, req_amount=5 → one err_insufficient pulse, no eject, remaining unchanged. Then req_amount=0 → done pulse, no eject.
- Timeout: balance=5, req_amount=1, eject_ack held 0 → fault high TIMEOUT+1 cycles after eject rises, eject low. abort → IDLE next cycle, fault low, remaining=1.
- Abort races:
  - abort together with eject_ack in EJECT → dec pulses, remaining decrements, IDLE, no done.
  - abort during RELEASE with ack high → stays in RELEASE until ack drops, then IDLE.
- Reset mid-payout: assert reset asynchronously while eject=1 → eject, busy and remaining go to 0 immediately. req_ready stays low while eject_ack remains high.
- Back-to-back: two requests (2 then 1 coin), with the second request held in req_valid → second accepted only once eject_ack is low in IDLE, total 3 dec strobes, two done strobes.
